// File: rtl/modexp_ladder_if.sv
// ---------------------------------------------------------------------------
// modexp_ladder_if
// Bundles the request side (start/operands/result) and the Montgomery
// multiplier side (mont_*) of the modular exponentiation controller.
//
// Signals
//   start, in_x, in_r, in_m, in_e, in_e_len : request from the host
//   busy, result, done                      : status and result to the host
//   mont_start, mont_a, mont_b, mont_m      : request to the multiplier
//   mont_result, mont_done                  : answer from the multiplier
//
// Modports
//   slave  : the exponentiation controller (modexp_ladder)
//   master : its environment, i.e. the host plus the multiplier
// ---------------------------------------------------------------------------
interface modexp_ladder_if #(
  parameter int N       = 1024,
  parameter int E_WIDTH = 1024,
  parameter int CNT_W   = 11
);

  logic                start;
  logic [N-1:0]        in_x;
  logic [N-1:0]        in_r;
  logic [N-1:0]        in_m;
  logic [E_WIDTH-1:0]  in_e;
  logic [CNT_W-1:0]    in_e_len;

  logic                busy;
  logic [N-1:0]        result;
  logic                done;

  logic                mont_start;
  logic [N-1:0]        mont_a;
  logic [N-1:0]        mont_b;
  logic [N-1:0]        mont_m;
  logic [N-1:0]        mont_result;
  logic                mont_done;

  modport slave (
    input  start, in_x, in_r, in_m, in_e, in_e_len,
    output busy, result, done,
    output mont_start, mont_a, mont_b, mont_m,
    input  mont_result, mont_done
  );

  modport master (
    output start, in_x, in_r, in_m, in_e, in_e_len,
    input  busy, result, done,
    input  mont_start, mont_a, mont_b, mont_m,
    output mont_result, mont_done
  );

endinterface

// File: rtl/modexp_ladder.sv
// ---------------------------------------------------------------------------
// modexp_ladder
// Left-to-right square-and-multiply controller for RSA modular
// exponentiation. It drives a Montgomery multiplier one request at a time,
// walking the exponent from bit t-1 down to bit 0, and finishes with a
// multiply by 1 that converts the accumulator back to normal form.
//
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   bus    : modexp_ladder_if.slave
//            start/in_x/in_r/in_m/in_e/in_e_len in, busy/result/done out,
//            mont_start/mont_a/mont_b/mont_m out, mont_result/mont_done in
//
// Operands handed to the multiplier are registers loaded on the edge that
// enters a request state, so they are already valid while mont_start is
// high and stay untouched until the matching mont_done.
// ---------------------------------------------------------------------------
module modexp_ladder #(
  parameter int N       = 1024,
  parameter int E_WIDTH = 1024,
  parameter int CNT_W   = 11
) (
  input  logic          clk,
  input  logic          reset,
  modexp_ladder_if.slave bus
);

  localparam int IDX_W = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(E_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [N-1:0]     ONE_N   = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    SQ_REQ,
    SQ_WAIT,
    MUL_REQ,
    MUL_WAIT,
    NEXT,
    POST_REQ,
    POST_WAIT,
    DONE
  } state_t;

  state_t             stateQ;
  logic [N-1:0]       xQ;
  logic [N-1:0]       mQ;
  logic [E_WIDTH-1:0] eQ;
  logic [CNT_W-1:0]   idxQ;
  logic [N-1:0]       accQ;
  logic [N-1:0]       montAQ;
  logic [N-1:0]       montBQ;
  logic               montStartQ;
  logic               busyQ;
  logic               doneQ;
  logic [N-1:0]       resultQ;

  logic [CNT_W-1:0]   tcD;
  logic               eBitD;

  // Exponent length clamped to the register width, and the exponent bit
  // selected by the current index (only the low IDX_W bits address eQ).
  always_comb begin
    tcD   = (bus.in_e_len > LEN_MAX) ? LEN_MAX : bus.in_e_len;
    eBitD = eQ[idxQ[IDX_W-1:0]];
  end

  // Main controller. mont_start and done default low every cycle and are
  // raised only on the edge that enters the state in which they must be
  // visible, giving single-cycle registered pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ     <= IDLE;
      xQ         <= '0;
      mQ         <= '0;
      eQ         <= '0;
      idxQ       <= '0;
      accQ       <= '0;
      montAQ     <= '0;
      montBQ     <= '0;
      montStartQ <= 1'b0;
      busyQ      <= 1'b0;
      doneQ      <= 1'b0;
      resultQ    <= '0;
    end else begin
      montStartQ <= 1'b0;
      doneQ      <= 1'b0;
      unique case (stateQ)
        IDLE: begin
          if (bus.start) begin
            busyQ  <= 1'b1;
            stateQ <= LOAD;
          end
        end

        // The accumulator starts at R mod m, the Montgomery form of 1; the
        // first request uses in_r straight from the port because accQ is
        // only being written on this same edge.
        LOAD: begin
          xQ         <= bus.in_x;
          mQ         <= bus.in_m;
          eQ         <= bus.in_e;
          accQ       <= bus.in_r;
          montAQ     <= bus.in_r;
          montStartQ <= 1'b1;
          if (tcD != '0) begin
            idxQ   <= tcD - CNT_ONE;
            montBQ <= bus.in_r;
            stateQ <= SQ_REQ;
          end else begin
            idxQ   <= '0;
            montBQ <= ONE_N;
            stateQ <= POST_REQ;
          end
        end

        SQ_REQ: stateQ <= SQ_WAIT;

        // A set bit chains the multiply straight off the square result,
        // skipping the NEXT cycle until the multiply has finished.
        SQ_WAIT: begin
          if (bus.mont_done) begin
            accQ <= bus.mont_result;
            if (eBitD) begin
              montAQ     <= bus.mont_result;
              montBQ     <= xQ;
              montStartQ <= 1'b1;
              stateQ     <= MUL_REQ;
            end else begin
              stateQ <= NEXT;
            end
          end
        end

        MUL_REQ: stateQ <= MUL_WAIT;

        MUL_WAIT: begin
          if (bus.mont_done) begin
            accQ   <= bus.mont_result;
            stateQ <= NEXT;
          end
        end

        // Either square again for the next lower bit, or leave the
        // Montgomery domain with a multiply by plain 1.
        NEXT: begin
          montAQ     <= accQ;
          montStartQ <= 1'b1;
          if (idxQ == '0) begin
            montBQ <= ONE_N;
            stateQ <= POST_REQ;
          end else begin
            montBQ <= accQ;
            idxQ   <= idxQ - CNT_ONE;
            stateQ <= SQ_REQ;
          end
        end

        POST_REQ: stateQ <= POST_WAIT;

        POST_WAIT: begin
          if (bus.mont_done) begin
            resultQ <= bus.mont_result;
            doneQ   <= 1'b1;
            stateQ  <= DONE;
          end
        end

        DONE: begin
          busyQ  <= 1'b0;
          stateQ <= IDLE;
        end

        default: begin
          busyQ  <= 1'b0;
          stateQ <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busyQ;
  assign bus.done       = doneQ;
  assign bus.result     = resultQ;
  assign bus.mont_start = montStartQ;
  assign bus.mont_a     = montAQ;
  assign bus.mont_b     = montBQ;
  assign bus.mont_m     = mQ;

endmodule

// File: tb/tb_modexp_ladder.sv
// ---------------------------------------------------------------------------
// tb_modexp_ladder
// Bench for modexp_ladder with a behavioural Montgomery multiplier of random
// latency, a protocol monitor, and golden results from plain modular
// arithmetic (right-to-left binary exponentiation on normal-form values).
// ---------------------------------------------------------------------------
module tb_modexp_ladder;

  localparam int N       = 1024;
  localparam int E_WIDTH = 1024;
  localparam int CNT_W   = 11;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  modexp_ladder_if #(.N(N), .E_WIDTH(E_WIDTH), .CNT_W(CNT_W)) bus ();

  modexp_ladder #(.N(N), .E_WIDTH(E_WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int nChecks = 0;
  int nPass   = 0;

  int latMin = 3;
  int latMax = 40;

  int           modelStarts = 0;
  int           protoViol   = 0;
  logic         modelDone   = 1'b0;
  logic         spuriousDone = 1'b0;
  logic [N-1:0] modelResult = '0;
  logic [N-1:0] lastA = '0;
  logic [N-1:0] lastB = '0;

  assign bus.mont_done   = modelDone | spuriousDone;
  assign bus.mont_result = modelResult;

  // Montgomery product a*b*2^-N mod m, bit-serial definition.
  function automatic logic [N-1:0] montMul(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [N-1:0] m);
    logic [N+1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) begin
      if (a[i]) s = s + {2'b00, b};
      if (s[0]) s = s + {2'b00, m};
      s = s >> 1;
    end
    if (s >= {2'b00, m}) s = s - {2'b00, m};
    return s[N-1:0];
  endfunction

  function automatic logic [N-1:0] toMont(input logic [N-1:0] v, input logic [N-1:0] m);
    logic [2*N-1:0] w;
    w = {v, {N{1'b0}}} % {{N{1'b0}}, m};
    return w[N-1:0];
  endfunction

  function automatic logic [N-1:0] rMod(input logic [N-1:0] m);
    logic [2*N-1:0] w;
    w    = '0;
    w[N] = 1'b1;
    w    = w % {{N{1'b0}}, m};
    return w[N-1:0];
  endfunction

  function automatic int clampLen(input logic [CNT_W-1:0] eLen);
    return (int'(eLen) > E_WIDTH) ? E_WIDTH : int'(eLen);
  endfunction

  function automatic logic [N-1:0] goldenPow(input logic [N-1:0] x, input logic [E_WIDTH-1:0] e,
                                             input int t, input logic [N-1:0] m);
    logic [2*N-1:0] mw, acc, base;
    mw   = {{N{1'b0}}, m};
    acc  = 1 % mw;
    base = {{N{1'b0}}, x} % mw;
    for (int i = 0; i < t; i++) begin
      if (e[i]) acc = (acc * base) % mw;
      base = (base * base) % mw;
    end
    return acc[N-1:0];
  endfunction

  function automatic int expStarts(input logic [E_WIDTH-1:0] e, input int t);
    int cnt;
    cnt = t + 1;
    for (int i = 0; i < t; i++) cnt += int'(e[i]);
    return cnt;
  endfunction

  function automatic logic [N-1:0] randN();
    logic [N-1:0] v;
    for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [E_WIDTH-1:0] randE();
    logic [E_WIDTH-1:0] v;
    for (int i = 0; i < E_WIDTH / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Behavioural multiplier plus protocol monitor, evaluated on falling edges.
  initial begin : montModel
    bit           outstanding;
    bit           prevDone;
    int           cnt;
    logic [N-1:0] capA, capB, capM, prod;
    outstanding = 1'b0;
    prevDone    = 1'b0;
    cnt         = 0;
    capA = '0; capB = '0; capM = '0; prod = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        outstanding = 1'b0;
        modelDone   = 1'b0;
        prevDone    = 1'b0;
      end else begin
        if (bus.done && prevDone) begin
          protoViol++;
          $display("[TB] protocol violation: done high for two cycles at %0t", $time);
        end
        prevDone = bus.done;
        if (outstanding && modelDone) begin
          modelDone   = 1'b0;
          outstanding = 1'b0;
        end
        if (outstanding) begin
          if (bus.mont_start) begin
            protoViol++;
            $display("[TB] protocol violation: second request in flight at %0t", $time);
          end
          if (bus.mont_a !== capA || bus.mont_b !== capB || bus.mont_m !== capM) begin
            protoViol++;
            $display("[TB] protocol violation: operands changed during request at %0t", $time);
          end
          cnt--;
          if (cnt <= 0) begin
            modelResult = prod;
            modelDone   = 1'b1;
          end
        end else if (bus.mont_start) begin
          capA = bus.mont_a;
          capB = bus.mont_b;
          capM = bus.mont_m;
          prod = montMul(capA, capB, capM);
          cnt  = $urandom_range(latMax, latMin);
          outstanding = 1'b1;
          modelStarts++;
          lastA = capA;
          lastB = capB;
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Runs one exponentiation; with disturb set, pulses mont_done during LOAD
  // and start repeatedly (with different inputs) while busy.
  task automatic applyStimulus(input logic [N-1:0] x, input logic [E_WIDTH-1:0] e,
                               input logic [CNT_W-1:0] eLen, input logic [N-1:0] m,
                               input bit disturb, input int budget,
                               output logic [N-1:0] res, output int dones,
                               output int starts, output int viols, output bit timedOut);
    int s0, v0;
    s0 = modelStarts;
    v0 = protoViol;
    dones = 0;
    res = '0;
    timedOut = 1'b1;
    @(negedge clk);
    bus.in_x     = toMont(x, m);
    bus.in_r     = rMod(m);
    bus.in_m     = m;
    bus.in_e     = e;
    bus.in_e_len = eLen;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (disturb) spuriousDone = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      spuriousDone = 1'b0;
      bus.start    = 1'b0;
      if (bus.done) begin
        dones++;
        res = bus.result;
        timedOut = 1'b0;
        break;
      end
      if (disturb && bus.busy && (c % 7 == 3)) begin
        bus.start    = 1'b1;
        bus.in_x     = randN();
        bus.in_e     = randE();
        bus.in_e_len = CNT_W'($urandom_range(2047, 0));
        bus.in_m     = randN() | 1;
      end
    end
    bus.start = 1'b0;
    spuriousDone = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    starts = modelStarts - s0;
    viols  = protoViol - v0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.in_x = '0; bus.in_r = '0; bus.in_m = '0; bus.in_e = '0; bus.in_e_len = '0;
    spuriousDone = 1'b0;
    repeat (3) @(negedge clk);
    nChecks++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy got %0b want 0", bus.busy); else nPass++;
    nChecks++; if (bus.done !== 1'b0) $display("[TB] FAIL reset_done got %0b want 0", bus.done); else nPass++;
    nChecks++; if (bus.mont_start !== 1'b0) $display("[TB] FAIL reset_mont_start got %0b want 0", bus.mont_start); else nPass++;
    nChecks++; if (bus.result !== '0) $display("[TB] FAIL reset_result got %0h want 0", bus.result[63:0]); else nPass++;
    nChecks++; if (bus.mont_a !== '0 || bus.mont_b !== '0 || bus.mont_m !== '0)
      $display("[TB] FAIL reset_operands got a=%0h b=%0h m=%0h want 0", bus.mont_a[63:0], bus.mont_b[63:0], bus.mont_m[63:0]);
    else nPass++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    nChecks++; if (bus.busy !== 1'b0) $display("[TB] FAIL idle_busy got %0b want 0", bus.busy); else nPass++;
  endtask

  task automatic test_case1();
    logic [N-1:0] res, m, x, gold;
    logic [E_WIDTH-1:0] e;
    int dones, starts, viols;
    bit tOut;
    latMin = 3; latMax = 40;
    m = N'(197); x = N'(7); e = E_WIDTH'(11);
    gold = goldenPow(x, e, 4, m);
    applyStimulus(x, e, CNT_W'(4), m, 1'b0, 2000, res, dones, starts, viols, tOut);
    nChecks++; if (tOut !== 1'b0) $display("[TB] FAIL case1_timeout got timeout want done"); else nPass++;
    nChecks++; if (res !== N'(116)) $display("[TB] FAIL case1_result got %0d want 116", res[63:0]); else nPass++;
    nChecks++; if (res !== gold) $display("[TB] FAIL case1_golden got %0d want %0d", res[63:0], gold[63:0]); else nPass++;
    nChecks++; if (starts !== 8) $display("[TB] FAIL case1_requests got %0d want 8", starts); else nPass++;
    nChecks++; if (dones !== 1) $display("[TB] FAIL case1_done_pulses got %0d want 1", dones); else nPass++;
    nChecks++; if (viols !== 0) $display("[TB] FAIL case1_protocol got %0d violations want 0", viols); else nPass++;
    nChecks++; if (bus.busy !== 1'b0) $display("[TB] FAIL case1_busy_after got %0b want 0", bus.busy); else nPass++;
  endtask

  task automatic test_zero_len();
    logic [N-1:0] res, m, x, r;
    int dones, starts, viols;
    bit tOut;
    m = (randN() >> $urandom_range(N - 2, 0)) | 3;
    x = randN() % m;
    r = rMod(m);
    applyStimulus(x, randE(), CNT_W'(0), m, 1'b0, 500, res, dones, starts, viols, tOut);
    nChecks++; if (starts !== 1) $display("[TB] FAIL zero_len_requests got %0d want 1", starts); else nPass++;
    nChecks++; if (lastA !== r) $display("[TB] FAIL zero_len_a got %0h want %0h", lastA[63:0], r[63:0]); else nPass++;
    nChecks++; if (lastB !== N'(1)) $display("[TB] FAIL zero_len_b got %0h want 1", lastB[63:0]); else nPass++;
    nChecks++; if (res !== N'(1)) $display("[TB] FAIL zero_len_result got %0h want 1", res[63:0]); else nPass++;
    nChecks++; if (dones !== 1 || tOut !== 1'b0) $display("[TB] FAIL zero_len_done got %0d pulses timeout=%0b want 1 0", dones, tOut); else nPass++;
  endtask

  task automatic test_random();
    logic [N-1:0] res, m, x, gold;
    logic [E_WIDTH-1:0] e;
    logic [CNT_W-1:0] eLen;
    int dones, starts, viols, t;
    bit tOut;
    latMin = 3; latMax = 40;
    for (int it = 0; it < 6; it++) begin
      m    = (randN() >> $urandom_range(N - 2, 0)) | 3;
      x    = randN() % m;
      e    = randE();
      eLen = CNT_W'($urandom_range(24, 1));
      t    = clampLen(eLen);
      gold = goldenPow(x, e, t, m);
      applyStimulus(x, e, eLen, m, 1'b0, 5000, res, dones, starts, viols, tOut);
      nChecks++; if (res !== gold) $display("[TB] FAIL random%0d_result got %0h want %0h", it, res[63:0], gold[63:0]); else nPass++;
      nChecks++; if (starts !== expStarts(e, t)) $display("[TB] FAIL random%0d_requests got %0d want %0d", it, starts, expStarts(e, t)); else nPass++;
      nChecks++; if (dones !== 1 || viols !== 0) $display("[TB] FAIL random%0d_protocol got done=%0d viol=%0d want 1 0", it, dones, viols); else nPass++;
    end
  endtask

  task automatic test_back_to_back_start();
    logic [N-1:0] res, m, x, gold;
    logic [E_WIDTH-1:0] e;
    logic [CNT_W-1:0] eLen;
    int dones, starts, viols, t, s0, sawDone;
    bit tOut;
    s0 = modelStarts;
    sawDone = 0;
    @(negedge clk);
    spuriousDone = 1'b1;
    @(negedge clk);
    spuriousDone = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy || bus.mont_start) sawDone++;
    end
    nChecks++; if (sawDone !== 0 || modelStarts !== s0)
      $display("[TB] FAIL idle_mont_done got activity=%0d requests=%0d want 0 0", sawDone, modelStarts - s0);
    else nPass++;
    m    = (randN() >> $urandom_range(N - 2, 0)) | 3;
    x    = randN() % m;
    e    = randE();
    eLen = CNT_W'($urandom_range(20, 8));
    t    = clampLen(eLen);
    gold = goldenPow(x, e, t, m);
    applyStimulus(x, e, eLen, m, 1'b1, 5000, res, dones, starts, viols, tOut);
    nChecks++; if (res !== gold) $display("[TB] FAIL busy_start_result got %0h want %0h", res[63:0], gold[63:0]); else nPass++;
    nChecks++; if (bus.result !== gold) $display("[TB] FAIL busy_start_result_held got %0h want %0h", bus.result[63:0], gold[63:0]); else nPass++;
    nChecks++; if (starts !== expStarts(e, t)) $display("[TB] FAIL busy_start_requests got %0d want %0d", starts, expStarts(e, t)); else nPass++;
    nChecks++; if (dones !== 1 || viols !== 0) $display("[TB] FAIL busy_start_protocol got done=%0d viol=%0d want 1 0", dones, viols); else nPass++;
  endtask

  task automatic test_reset_midop();
    logic [N-1:0] res, m, x;
    int dones, starts, viols;
    bit tOut, seen;
    latMin = 3; latMax = 40;
    m = N'(197); x = N'(7);
    @(negedge clk);
    bus.in_x = toMont(x, m); bus.in_r = rMod(m); bus.in_m = m;
    bus.in_e = E_WIDTH'(11); bus.in_e_len = CNT_W'(4);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.mont_start) begin seen = 1'b1; break; end
    end
    nChecks++; if (seen !== 1'b1) $display("[TB] FAIL midop_first_request got none want mont_start"); else nPass++;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    nChecks++; if (bus.busy !== 1'b0 || bus.mont_start !== 1'b0 || bus.done !== 1'b0)
      $display("[TB] FAIL midop_reset got busy=%0b start=%0b done=%0b want 0 0 0", bus.busy, bus.mont_start, bus.done);
    else nPass++;
    nChecks++; if (bus.result !== '0) $display("[TB] FAIL midop_reset_result got %0h want 0", bus.result[63:0]); else nPass++;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(x, E_WIDTH'(11), CNT_W'(4), m, 1'b0, 2000, res, dones, starts, viols, tOut);
    nChecks++; if (res !== N'(116)) $display("[TB] FAIL midop_rerun_result got %0d want 116", res[63:0]); else nPass++;
    nChecks++; if (starts !== 8 || dones !== 1 || viols !== 0)
      $display("[TB] FAIL midop_rerun got req=%0d done=%0d viol=%0d want 8 1 0", starts, dones, viols);
    else nPass++;
  endtask

  task automatic test_full_width();
    logic [N-1:0] res, m, x, gold;
    logic [E_WIDTH-1:0] e;
    logic [CNT_W-1:0] lens [2];
    int dones, starts, viols;
    bit tOut;
    latMin = 3; latMax = 5;
    m = randN();
    m[N-1] = 1'b1;
    m[0]   = 1'b1;
    x = randN() % m;
    e = '1;
    gold = goldenPow(x, e, E_WIDTH, m);
    lens[0] = CNT_W'(E_WIDTH);
    lens[1] = CNT_W'(2047);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(x, e, lens[i], m, 1'b0, 30000, res, dones, starts, viols, tOut);
      nChecks++; if (tOut !== 1'b0) $display("[TB] FAIL full%0d_timeout got timeout want done", i); else nPass++;
      nChecks++; if (res !== gold) $display("[TB] FAIL full%0d_result got %0h want %0h", i, res[63:0], gold[63:0]); else nPass++;
      nChecks++; if (starts !== 2049) $display("[TB] FAIL full%0d_requests got %0d want 2049", i, starts); else nPass++;
      nChecks++; if (dones !== 1 || viols !== 0) $display("[TB] FAIL full%0d_protocol got done=%0d viol=%0d want 1 0", i, dones, viols); else nPass++;
    end
    latMin = 3; latMax = 40;
  endtask

  initial begin : mainSeq
    test_reset();
    test_case1();
    test_zero_len();
    test_random();
    test_back_to_back_start();
    test_reset_midop();
    test_full_width();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
